// File: rtl/ans_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ans_stream_decoder
// Description : Table-driven ANS (asymmetric numeral system) stream decoder.
//               The frequency table is external and is reached through a
//               request/acknowledge port. The port carries PMF, inclusive CMF
//               and ICMF (slot to symbol) queries.
//               Flow for one frame:
//                 1. Read the table total M = CMF(SYM_COUNT-1).
//                 2. Load the decoder state x from the stream, LS word first.
//                 3. Repeat until all symbols are out:
//                      decode  slot = x mod M,  symbol = ICMF(slot)
//                      update  x = (x/M)*PMF(s) + slot - CMF(s-1)
//                      renorm  shift in stream words while x < M
//               Ports:
//                 clk, rst                 clock, synchronous active-high reset
//                 ena                      clock enable (low: everything holds)
//                 start, num_syms          frame start, symbols in this frame
//                 in/in_vld/in_rdy         stream word input handshake
//                 out/out_vld/out_rdy      decoded symbol output handshake
//                 read_type/read_query     table request (NONE/PMF/CMF/ICMF)
//                 read_result/read_rdy     table response
//                 done, err                frame complete / zero table total
//                 sym_count                symbols accepted in this frame
//               Build option: define ANS_DEC_SYM_COUNTER_EN to expose the
//               running symbol count on sym_count. Without it, sym_count
//               reads constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
module ans_stream_decoder #(
    parameter int SYM_WIDTH   = 4,
    parameter int CNT_WIDTH   = 4,
    parameter int STATE_WIDTH = 16,
    parameter int SYM_COUNT   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena,
    input  logic                           start,
    input  logic [CNT_WIDTH-1:0]           num_syms,
    input  logic [SYM_WIDTH-1:0]           in,
    input  logic                           in_vld,
    output logic                           in_rdy,
    output logic [SYM_WIDTH-1:0]           out,
    output logic                           out_vld,
    input  logic                           out_rdy,
    output logic [1:0]                     read_type,
    output logic [CNT_WIDTH+SYM_WIDTH-1:0] read_query,
    input  logic [CNT_WIDTH+SYM_WIDTH-1:0] read_result,
    input  logic                           read_rdy,
    output logic                           done,
    output logic                           err,
    output logic [CNT_WIDTH-1:0]           sym_count
);

    localparam int c_QW    = CNT_WIDTH + SYM_WIDTH;
    localparam int c_WORDS = STATE_WIDTH / SYM_WIDTH;
    localparam int c_WCW   = $clog2(c_WORDS + 1);

    localparam logic [1:0] c_RT_NONE = 2'd0;
    localparam logic [1:0] c_RT_PMF  = 2'd1;
    localparam logic [1:0] c_RT_CMF  = 2'd2;
    localparam logic [1:0] c_RT_ICMF = 2'd3;

    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_LOAD_TOTAL = 3'd1;
    localparam logic [2:0] c_ST_LOAD_STATE = 3'd2;
    localparam logic [2:0] c_ST_DECODE     = 3'd3;
    localparam logic [2:0] c_ST_UPDATE     = 3'd4;
    localparam logic [2:0] c_ST_RENORM     = 3'd5;
    localparam logic [2:0] c_ST_DONE       = 3'd6;

    localparam logic [c_WCW-1:0]       c_LAST_WORD = c_WCW'(c_WORDS - 1);
    localparam logic [c_WCW-1:0]       c_WORD_ONE  = c_WCW'(1);
    localparam logic [CNT_WIDTH-1:0]   c_CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [SYM_WIDTH-1:0]   c_SYM_ONE   = SYM_WIDTH'(1);
    localparam logic [STATE_WIDTH-1:0] c_X_ONE     = STATE_WIDTH'(1);

    // r_phase is a sub-step inside a state. Every table request phase is
    // followed by a phase with read_type = NONE, so there is always an idle
    // cycle between two requests.
    //   LOAD_TOTAL: 0 = CMF(SYM_COUNT-1) request, 1 = check M
    //   DECODE    : 0 = ICMF(slot) request,      1 = symbol presented
    //   UPDATE    : 0 = PMF(s) request, 1 = gap, 2 = CMF(s-1) request,
    //               3 = compute x'
    logic [2:0]             r_state;
    logic [1:0]             r_phase;
    logic [STATE_WIDTH-1:0] r_x;
    logic [STATE_WIDTH-1:0] r_m;
    logic [STATE_WIDTH-1:0] r_slot;
    logic [STATE_WIDTH-1:0] r_pmf;
    logic [STATE_WIDTH-1:0] r_cmf;
    logic [SYM_WIDTH-1:0]   r_sym;
    logic [SYM_WIDTH-1:0]   r_out;
    logic                   r_out_vld;
    logic                   r_err;
    logic [CNT_WIDTH-1:0]   r_num;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [c_WCW-1:0]       r_words;

    logic [2:0]             w_state_nxt;
    logic [1:0]             w_phase_nxt;
    logic [STATE_WIDTH-1:0] w_div;
    logic [STATE_WIDTH-1:0] w_quot;
    logic [STATE_WIDTH-1:0] w_rem;
    logic [STATE_WIDTH-1:0] w_xnew;
    logic [STATE_WIDTH-1:0] w_load_x;
    logic [STATE_WIDTH-1:0] w_ren_x;
    logic [CNT_WIDTH-1:0]   w_cnt_inc;
    logic                   w_in_xfer;
    logic                   w_out_xfer;

    // The divisor is forced nonzero so that the idle datapath never divides
    // by zero. M is always nonzero whenever the quotient or remainder is used.
    assign w_div      = (r_m == '0) ? c_X_ONE : r_m;
    assign w_quot     = r_x / w_div;
    assign w_rem      = r_x % w_div;
    assign w_xnew     = w_quot * r_pmf + r_slot - r_cmf;
    // The state loads LS word first, so each new word enters at the top.
    assign w_load_x   = {in, r_x[STATE_WIDTH-1:SYM_WIDTH]};
    assign w_ren_x    = {r_x[STATE_WIDTH-SYM_WIDTH-1:0], in};
    assign w_cnt_inc  = r_cnt + c_CNT_ONE;
    assign w_in_xfer  = in_vld && in_rdy;
    assign w_out_xfer = r_out_vld && out_rdy;

    // State register and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_phase   <= 2'd0;
            r_x       <= '0;
            r_m       <= '0;
            r_slot    <= '0;
            r_pmf     <= '0;
            r_cmf     <= '0;
            r_sym     <= '0;
            r_out     <= '0;
            r_out_vld <= 1'b0;
            r_err     <= 1'b0;
            r_num     <= '0;
            r_cnt     <= '0;
            r_words   <= '0;
        end else if (ena) begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        r_num   <= num_syms;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_words <= '0;
                        r_x     <= '0;
                    end
                end
                c_ST_LOAD_TOTAL: begin
                    if (r_phase == 2'd0 && read_rdy) begin
                        r_m <= STATE_WIDTH'(read_result);
                    end else if (r_phase == 2'd1 && r_m == '0) begin
                        r_err <= 1'b1;
                    end
                end
                c_ST_LOAD_STATE: begin
                    if (w_in_xfer) begin
                        r_x     <= w_load_x;
                        r_words <= r_words + c_WORD_ONE;
                    end
                end
                c_ST_DECODE: begin
                    if (r_phase == 2'd0 && read_rdy) begin
                        r_out     <= read_result[SYM_WIDTH-1:0];
                        r_sym     <= read_result[SYM_WIDTH-1:0];
                        r_slot    <= w_rem;
                        r_out_vld <= 1'b1;
                    end else if (r_phase == 2'd1 && w_out_xfer) begin
                        r_out_vld <= 1'b0;
                        r_cnt     <= w_cnt_inc;
                    end
                end
                c_ST_UPDATE: begin
                    case (r_phase)
                        2'd0: if (read_rdy) r_pmf <= STATE_WIDTH'(read_result);
                        2'd1: if (r_sym == '0) r_cmf <= '0;
                        2'd2: if (read_rdy) r_cmf <= STATE_WIDTH'(read_result);
                        default: r_x <= w_xnew;
                    endcase
                end
                c_ST_RENORM: begin
                    if (w_in_xfer) r_x <= w_ren_x;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                if (start) begin
                    w_state_nxt = c_ST_LOAD_TOTAL;
                    w_phase_nxt = 2'd0;
                end
            end
            c_ST_LOAD_TOTAL: begin
                if (r_phase == 2'd0) begin
                    if (read_rdy) w_phase_nxt = 2'd1;
                end else begin
                    w_phase_nxt = 2'd0;
                    w_state_nxt = (r_m == '0) ? c_ST_DONE : c_ST_LOAD_STATE;
                end
            end
            c_ST_LOAD_STATE: begin
                if (w_in_xfer && r_words == c_LAST_WORD) begin
                    w_state_nxt = (r_num == '0) ? c_ST_DONE : c_ST_DECODE;
                end
            end
            c_ST_DECODE: begin
                if (r_phase == 2'd0) begin
                    if (read_rdy) w_phase_nxt = 2'd1;
                end else if (w_out_xfer) begin
                    w_phase_nxt = 2'd0;
                    w_state_nxt = (w_cnt_inc == r_num) ? c_ST_DONE : c_ST_UPDATE;
                end
            end
            c_ST_UPDATE: begin
                case (r_phase)
                    2'd0: if (read_rdy) w_phase_nxt = 2'd1;
                    // Symbol 0 has no predecessor: skip the CMF read.
                    2'd1: w_phase_nxt = (r_sym == '0) ? 2'd3 : 2'd2;
                    2'd2: if (read_rdy) w_phase_nxt = 2'd3;
                    default: begin
                        w_phase_nxt = 2'd0;
                        w_state_nxt = (w_xnew < r_m) ? c_ST_RENORM : c_ST_DECODE;
                    end
                endcase
            end
            c_ST_RENORM: begin
                if (w_in_xfer && w_ren_x >= r_m) w_state_nxt = c_ST_DECODE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_phase_nxt = 2'd0;
            end
        endcase
    end

    // Output decode. in_rdy is qualified by ena so that no word is
    // handshaked while the decoder is frozen.
    always_comb begin
        in_rdy     = 1'b0;
        read_type  = c_RT_NONE;
        read_query = '0;
        case (r_state)
            c_ST_LOAD_TOTAL: begin
                if (r_phase == 2'd0) begin
                    read_type  = c_RT_CMF;
                    read_query = c_QW'(SYM_COUNT - 1);
                end
            end
            c_ST_LOAD_STATE: in_rdy = ena;
            c_ST_DECODE: begin
                if (r_phase == 2'd0) begin
                    read_type  = c_RT_ICMF;
                    read_query = w_rem[c_QW-1:0];
                end
            end
            c_ST_UPDATE: begin
                if (r_phase == 2'd0) begin
                    read_type  = c_RT_PMF;
                    read_query = c_QW'(r_sym);
                end else if (r_phase == 2'd2) begin
                    read_type  = c_RT_CMF;
                    read_query = c_QW'(r_sym - c_SYM_ONE);
                end
            end
            c_ST_RENORM: in_rdy = ena;
            default: ;
        endcase
    end

    assign out     = r_out;
    assign out_vld = r_out_vld;
    assign done    = (r_state == c_ST_DONE);
    assign err     = r_err;

`ifdef ANS_DEC_SYM_COUNTER_EN
    assign sym_count = r_cnt;
`else
    assign sym_count = '0;
`endif

endmodule
`default_nettype wire

// File: doc/ans_stream_decoder.md
ANS_STREAM_DECODER -- requirements
Module: ans_stream_decoder

Interface
REQ-001 SHALL have parameter SYM_WIDTH, default 4: width of each symbol and of each input stream word.
REQ-002 SHALL have parameter CNT_WIDTH, default 4: width of frequency counts and of the num_syms field.
REQ-003 SHALL have parameter STATE_WIDTH, default 16: decoder state width; integer multiple of SYM_WIDTH.
REQ-004 SHALL have parameter SYM_COUNT, default 16: alphabet size; at most 2^SYM_WIDTH.
REQ-005 SHALL have port clk  input  1  sole clock; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port ena  input  1  when low, all state holds.
REQ-008 SHALL have port start  input  1  begins a frame when sampled high in IDLE.
REQ-009 SHALL have port num_syms  input  CNT_WIDTH  symbols to decode; captured on start.
REQ-010 SHALL have ports in/in_vld/in_rdy  input/input/output  SYM_WIDTH/1/1  stream word handshake.
REQ-011 SHALL have ports out/out_vld/out_rdy  output/output/input  SYM_WIDTH/1/1  decoded symbol handshake.
REQ-012 SHALL have ports read_type/read_query/read_result/read_rdy  output/output/input/input  2/CNT_WIDTH+SYM_WIDTH/CNT_WIDTH+SYM_WIDTH/1  frequency table port.
REQ-013 SHALL have ports done/err  output/output  1/1  frame complete / table fault.
REQ-014 SHALL use read_type encoding NONE=0, PMF=1, CMF=2 (inclusive cumulative), ICMF=3 (slot to symbol).

Function
REQ-015 SHALL implement states IDLE, LOAD_TOTAL, LOAD_STATE, DECODE, UPDATE, RENORM, DONE.
REQ-016 IDLE: on start, SHALL capture num_syms, clear symbol counter, go LOAD_TOTAL; done/err cleared.
REQ-017 Table handshake: read_type/read_query SHALL stay stable until read_rdy is sampled high, then return to NONE for at least one cycle before the next request.
REQ-018 LOAD_TOTAL SHALL issue CMF(SYM_COUNT-1) and latch the result as M; M==0 SHALL set err=1 and go DONE.
REQ-019 LOAD_STATE SHALL accept STATE_WIDTH/SYM_WIDTH words, least-significant word first; in_rdy high only in LOAD_STATE and RENORM; a word transfers on in_vld && in_rdy.
REQ-020 num_syms==0 SHALL go DONE after LOAD_STATE with no output.
REQ-021 DECODE SHALL compute slot = x mod M, issue ICMF(slot), present result on out with out_vld=1; out SHALL stay stable until out_rdy.
REQ-022 On out accept, counter increments; if counter equals num_syms SHALL go DONE, else UPDATE.
REQ-023 UPDATE SHALL compute x' = (x / M) * PMF(s) + slot - CMF(s-1); CMF read SHALL be skipped and treated as 0 when s==0; arithmetic in STATE_WIDTH bits, truncating.
REQ-024 RENORM SHALL repeat x = (x << SYM_WIDTH) | in, one word per transfer, while x < M, then go DECODE; x >= M skips RENORM.
REQ-025 DONE SHALL assert done=1 and hold until start, which behaves as in IDLE.
REQ-026 Minimum symbol period: ICMF request to out_vld no more than 2 cycles after read_rdy.

Reset
REQ-027 rst SHALL, at the next clk edge regardless of ena, force IDLE, counter 0, x 0, M 0, and outputs in_rdy=0, out=0, out_vld=0, read_type=NONE, read_query=0, done=0, err=0.
REQ-028 rst mid-frame SHALL abandon any pending table request and transfer; no stale out_vld afterwards.

Configuration
REQ-029 With macro ANS_DEC_SYM_COUNTER_EN defined, port sym_count (output, CNT_WIDTH) SHALL show symbols accepted this frame; without it the port SHALL exist and read constant 0, with no counter logic beyond REQ-022.

Verification (uniform table: PMF=1, CMF(s)=s+1, ICMF(k)=k, M=16, defaults)
REQ-030 start, num_syms=3, words 1,2,3,4 -> out 1,2,3 then done=1, err=0, no further in_rdy.
REQ-031 start, num_syms=5, words 1,2,3,4,7,5 -> out 1,2,3,7,5; exactly 2 RENORM words consumed.
REQ-032 CMF(15) returns 0 -> err=1, done=1, out_vld never asserted, in_rdy never asserted.
REQ-033 out_rdy low 10 cycles during REQ-030 -> out and out_vld held stable; sequence unchanged.
REQ-034 rst pulse after second output of REQ-031, then rerun REQ-030 -> outputs 1,2,3, no residue.
REQ-035 read_rdy delayed 5 cycles per request -> read_type/read_query stable throughout; outputs unchanged.
